// File: rtl/sdpb_mem_arbiter_pkg.sv
// sdpb_arb_pkg: shared widths, read-FSM states and read-owner tags for sdpb_mem_arbiter.
// No ports; imported by the interface, the write arbiter and the top.
package sdpb_arb_pkg;
    localparam int AW_DEF = 13;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {IDLE, BURST, CPU_SLOT} rd_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
endpackage

// File: rtl/sdpb_mem_arbiter_if.sv
// sdpb_mem_arbiter_if: bundle of requester-side and BRAM-side signals around the arbiter.
// Ports: none. Modports:
//   slave  - arbiter view: vid/cpu/ldr requests and mem_dout in; grants, read beats, BRAM controls out
//   master - requester/BRAM view: the mirror image of slave
interface sdpb_mem_arbiter_if
    import sdpb_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          vid_req, vid_gnt, vid_rvalid, vid_rlast;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          cpu_rreq, cpu_rgnt, cpu_rvalid;
    logic [AW-1:0] cpu_raddr;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_wreq, cpu_wgnt, ldr_wreq, ldr_wgnt;
    logic [AW-1:0] cpu_waddr, ldr_waddr;
    logic [DW-1:0] cpu_wdata, ldr_wdata;
    logic          mem_cea, mem_ceb, mem_oce;
    logic [AW-1:0] mem_ada, mem_adb;
    logic [DW-1:0] mem_din, mem_dout;
    modport slave (
        input  vid_req, vid_addr, cpu_rreq, cpu_raddr,
        input  cpu_wreq, cpu_waddr, cpu_wdata, ldr_wreq, ldr_waddr, ldr_wdata, mem_dout,
        output vid_gnt, vid_rvalid, vid_rlast, vid_rdata, cpu_rgnt, cpu_rvalid, cpu_rdata,
        output cpu_wgnt, ldr_wgnt, mem_cea, mem_ada, mem_din, mem_ceb, mem_adb, mem_oce
    );
    modport master (
        output vid_req, vid_addr, cpu_rreq, cpu_raddr,
        output cpu_wreq, cpu_waddr, cpu_wdata, ldr_wreq, ldr_waddr, ldr_wdata, mem_dout,
        input  vid_gnt, vid_rvalid, vid_rlast, vid_rdata, cpu_rgnt, cpu_rvalid, cpu_rdata,
        input  cpu_wgnt, ldr_wgnt, mem_cea, mem_ada, mem_din, mem_ceb, mem_adb, mem_oce
    );
endinterface

// File: rtl/sdpb_mem_arbiter_rr_write_arbiter.sv
// rr_write_arbiter: 2-way round-robin grant and address/data mux for BRAM write port A.
// Ports: clk, reset (sync, active-high); cpu/ldr wreq, waddr, wdata in;
//        cpu_wgnt, ldr_wgnt, wen, waddr, wdata out (grants are combinational).
module rr_write_arbiter
    import sdpb_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_wreq,
    input  logic [AW-1:0] cpu_waddr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          ldr_wreq,
    input  logic [AW-1:0] ldr_waddr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          cpu_wgnt,
    output logic          ldr_wgnt,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);
    // ptr = 0 favours the CPU on contention, 1 favours the loader
    logic ptr;

    assign cpu_wgnt = cpu_wreq && (!ldr_wreq || !ptr);
    assign ldr_wgnt = ldr_wreq && (!cpu_wreq || ptr);
    assign wen      = cpu_wgnt || ldr_wgnt;
    assign waddr    = ldr_wgnt ? ldr_waddr : cpu_waddr;
    assign wdata    = ldr_wgnt ? ldr_wdata : cpu_wdata;

    // Only a contended cycle moves the pointer, handing the next tie to the loser
    always_ff @(posedge clk) begin
        if (reset) ptr <= 1'b0;
        else if (cpu_wreq && ldr_wreq) ptr <= !ptr;
    end
endmodule

// File: rtl/sdpb_mem_arbiter.sv
// sdpb_mem_arbiter: shares an 8192x16 simple-dual-port BRAM; read port B serves video bursts
// (priority, with forced CPU slots against starvation) and CPU reads; write port A is
// round-robin between CPU and loader.
// Ports: clk, reset (sync, active-high), bus (sdpb_mem_arbiter_if.slave).
// Option: define SDPB_WR_FWD_EN to return the new write data on a same-cycle same-address read.
module sdpb_mem_arbiter
    import sdpb_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int BURST_LEN  = 16,
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic reset,
    sdpb_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    rd_state_t     state, state_n;
    owner_t        own, own_n;
    logic          last, last_n;
    logic [AW-1:0] base;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic [DW-1:0] rdata;

    always_comb begin
        state_n      = state;
        own_n        = OWN_NONE;
        last_n       = 1'b0;
        bus.vid_gnt  = 1'b0;
        bus.cpu_rgnt = 1'b0;
        bus.mem_ceb  = 1'b0;
        bus.mem_adb  = bus.cpu_raddr;
        case (state)
            IDLE: begin
                if (bus.vid_req) begin
                    bus.vid_gnt = 1'b1;
                    state_n     = BURST;
                end else if (bus.cpu_rreq) begin
                    bus.cpu_rgnt = 1'b1;
                    bus.mem_ceb  = 1'b1;
                    own_n        = OWN_CPU;
                end
            end
            BURST: begin
                if (starve == SW'(STARVE_MAX)) begin
                    state_n = CPU_SLOT;
                end else begin
                    bus.mem_ceb = 1'b1;
                    bus.mem_adb = base + AW'(cnt);
                    own_n       = OWN_VID;
                    last_n      = cnt == CW'(BURST_LEN - 1);
                    state_n     = last_n ? IDLE : BURST;
                end
            end
            CPU_SLOT: begin
                state_n      = BURST;
                bus.cpu_rgnt = bus.cpu_rreq;
                bus.mem_ceb  = bus.cpu_rreq;
                own_n        = bus.cpu_rreq ? OWN_CPU : OWN_NONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            own    <= OWN_NONE;
            last   <= 1'b0;
            base   <= '0;
            cnt    <= '0;
            starve <= '0;
        end else begin
            state <= state_n;
            own   <= own_n;
            last  <= last_n;
            if (bus.vid_gnt) begin
                base   <= bus.vid_addr;
                cnt    <= '0;
                starve <= '0;
            end
            if (own_n == OWN_VID) cnt <= cnt + CW'(1);
            // Only issued video beats age a waiting CPU read
            if (own_n == OWN_VID && bus.cpu_rreq) starve <= starve + SW'(1);
            if (state == CPU_SLOT) starve <= '0;
        end
    end

`ifdef SDPB_WR_FWD_EN
    // BRAM returns stale data on a same-address collision; replay the write data instead
    logic          fwd;
    logic [DW-1:0] fwd_data;
    always_ff @(posedge clk) begin
        if (reset) fwd <= 1'b0;
        else fwd <= bus.mem_cea && bus.mem_ceb && bus.mem_ada == bus.mem_adb;
        fwd_data <= bus.mem_din;
    end
    assign rdata = fwd ? fwd_data : bus.mem_dout;
`else
    assign rdata = bus.mem_dout;
`endif

    assign bus.vid_rvalid = own == OWN_VID;
    assign bus.vid_rlast  = own == OWN_VID && last;
    assign bus.cpu_rvalid = own == OWN_CPU;
    assign bus.vid_rdata  = rdata;
    assign bus.cpu_rdata  = rdata;
    assign bus.mem_oce    = 1'b1;

    rr_write_arbiter #(.AW(AW), .DW(DW)) u_wr (
        .clk      (clk),
        .reset    (reset),
        .cpu_wreq (bus.cpu_wreq),
        .cpu_waddr(bus.cpu_waddr),
        .cpu_wdata(bus.cpu_wdata),
        .ldr_wreq (bus.ldr_wreq),
        .ldr_waddr(bus.ldr_waddr),
        .ldr_wdata(bus.ldr_wdata),
        .cpu_wgnt (bus.cpu_wgnt),
        .ldr_wgnt (bus.ldr_wgnt),
        .wen      (bus.mem_cea),
        .waddr    (bus.mem_ada),
        .wdata    (bus.mem_din)
    );
endmodule
